// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Jumps resolve in fetch, branches redirect from later stages, and a run of zero words halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          HALT_ZEROS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] instAddr,
    input  logic [31:0] instIn,
    output logic [31:0] ifidInst,
    output logic [31:0] ifidPcPlus1,
    output logic        ifidValid,
    output logic        halted,
    output logic [31:0] fetchCount
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [3:0] HALT_CNT = 4'(HALT_ZEROS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pp1_q, pp1_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  zrun_q, zrun_d;

    logic [31:0] pc_plus1;
    logic [31:0] jump_target;
    logic        is_jump;
    logic        is_zero;
    logic [3:0]  zrun_inc;
    logic        seq_fetch;

    assign pc_plus1    = pc_q + 32'd1;
    assign is_jump     = (instIn[31:26] == 6'b000010);
    assign jump_target = {pc_plus1[31:26], instIn[25:0]};
    assign is_zero     = (instIn == 32'd0);
    assign zrun_inc    = zrun_q + 4'd1;
    // A plain sequential fetch: the only case that writes a real instruction into IF/ID.
    assign seq_fetch   = !branchTaken && !stall && !is_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            pp1_q   <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
            zrun_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pp1_q   <= pp1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            zrun_q  <= zrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && seq_fetch && is_zero && zrun_inc == HALT_CNT)
            state_d = S_HALT;
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pp1_d   = pp1_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        zrun_d  = zrun_q;
        case (state_q)
            S_RUN: begin
                if (branchTaken) begin
                    pc_d    = branchTarget;
                    inst_d  = 32'd0;
                    pp1_d   = 32'd0;
                    valid_d = 1'b0;
                    zrun_d  = 4'd0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (is_jump) begin
                    // Jump word is consumed here; decode sees a bubble instead.
                    pc_d    = jump_target;
                    inst_d  = 32'd0;
                    pp1_d   = 32'd0;
                    valid_d = 1'b0;
                    zrun_d  = 4'd0;
                end else begin
                    pc_d    = pc_plus1;
                    inst_d  = instIn;
                    pp1_d   = pc_plus1;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    zrun_d  = is_zero ? zrun_inc : 4'd0;
                end
            end
            default: begin
                inst_d  = 32'd0;
                pp1_d   = 32'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        halted      = (state_q == S_HALT);
        instAddr    = pc_q;
        ifidInst    = inst_q;
        ifidPcPlus1 = pp1_q;
        ifidValid   = valid_q;
        fetchCount  = cnt_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural ROM; expectations are hand-derived.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] instAddr;
    logic [31:0] instIn;
    logic [31:0] ifidInst;
    logic [31:0] ifidPcPlus1;
    logic        ifidValid;
    logic        halted;
    logic [31:0] fetchCount;

    logic [31:0] rom [0:63];
    int errors = 0;
    int checks = 0;

    localparam logic [31:0] WRAP_WORD = 32'h1234_5678;

    fetch_unit #(.RESET_PC(32'd0), .HALT_ZEROS(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .instAddr(instAddr), .instIn(instIn),
        .ifidInst(ifidInst), .ifidPcPlus1(ifidPcPlus1), .ifidValid(ifidValid),
        .halted(halted), .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (instAddr == 32'hFFFF_FFFF) instIn = WRAP_WORD;
        else if (instAddr < 32'd64)    instIn = rom[instAddr[5:0]];
        else                           instIn = 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; rst_n = 0; stall = 0; branchTaken = 0; branchTarget = 32'd0;
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        for (int i = 0; i < 12; i++) rom[i] = 32'h0000_0020 | (i << 11);
        rom[5] = {6'b000010, 26'd8};

        // Reset state
        #2;
        chk("rst_addr", instAddr, 32'd0);
        chk("rst_inst", ifidInst, 32'd0);
        chk("rst_pp1", ifidPcPlus1, 32'd0);
        chk("rst_valid", {31'd0, ifidValid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt", fetchCount, 32'd0);
        #1 rst_n = 1;

        // Sequential fetch of words 0..4
        for (int i = 0; i < 5; i++) begin
            step();
            chk("seq_addr", instAddr, 32'(i + 1));
            chk("seq_pp1", ifidPcPlus1, 32'(i + 1));
            chk("seq_inst", ifidInst, 32'h0000_0020 | (i << 11));
            chk("seq_valid", {31'd0, ifidValid}, 32'd1);
        end
        chk("seq_cnt", fetchCount, 32'd5);

        // Jump at 5 -> 8, one bubble
        step();
        chk("jmp_addr", instAddr, 32'd8);
        chk("jmp_valid", {31'd0, ifidValid}, 32'd0);
        chk("jmp_cnt", fetchCount, 32'd5);
        for (int i = 8; i < 12; i++) begin
            step();
            chk("post_jmp_pp1", ifidPcPlus1, 32'(i + 1));
            chk("post_jmp_valid", {31'd0, ifidValid}, 32'd1);
        end
        chk("post_jmp_addr", instAddr, 32'd12);
        chk("post_jmp_cnt", fetchCount, 32'd9);

        // Zero run 12..15 -> halt
        for (int i = 12; i < 15; i++) begin
            step();
            chk("zero_halted", {31'd0, halted}, 32'd0);
            chk("zero_valid", {31'd0, ifidValid}, 32'd1);
        end
        step();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_addr", instAddr, 32'd16);
        chk("halt_last_pp1", ifidPcPlus1, 32'd16);
        chk("halt_last_valid", {31'd0, ifidValid}, 32'd1);
        chk("halt_cnt", fetchCount, 32'd13);
        step();
        chk("halt_bubble", {31'd0, ifidValid}, 32'd0);
        branchTaken = 1; branchTarget = 32'd3;
        step();
        chk("halt_ign_br_addr", instAddr, 32'd16);
        chk("halt_ign_br_flag", {31'd0, halted}, 32'd1);
        chk("halt_ign_br_cnt", fetchCount, 32'd13);
        branchTaken = 0;

        // Fresh reset, then stall at PC=2
        rst_n = 0;
        #1;
        chk("rst2_addr", instAddr, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        rst_n = 1;
        step();
        step();
        chk("pre_stall_addr", instAddr, 32'd2);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", instAddr, 32'd2);
            chk("stall_pp1", ifidPcPlus1, 32'd2);
            chk("stall_inst", ifidInst, 32'h0000_0820);
            chk("stall_cnt", fetchCount, 32'd2);
        end
        branchTaken = 1; branchTarget = 32'd9;
        step();
        chk("stall_br_addr", instAddr, 32'd9);
        chk("stall_br_valid", {31'd0, ifidValid}, 32'd0);
        chk("stall_br_cnt", fetchCount, 32'd2);
        stall = 0; branchTaken = 0;
        step();
        chk("br9_pp1", ifidPcPlus1, 32'd10);
        chk("br9_valid", {31'd0, ifidValid}, 32'd1);

        // Reach PC=7, then async reset between edges
        branchTaken = 1; branchTarget = 32'd6;
        step();
        branchTaken = 0;
        step();
        chk("pc7_addr", instAddr, 32'd7);
        chk("pc7_cnt", fetchCount, 32'd4);
        #2 rst_n = 0;
        #1;
        chk("async_addr", instAddr, 32'd0);
        chk("async_valid", {31'd0, ifidValid}, 32'd0);
        chk("async_cnt", fetchCount, 32'd0);
        #1 rst_n = 1;
        step();
        chk("restart_addr", instAddr, 32'd1);
        chk("restart_pp1", ifidPcPlus1, 32'd1);

        // Wrap from 32'hFFFFFFFF
        branchTaken = 1; branchTarget = 32'hFFFF_FFFF;
        step();
        branchTaken = 0;
        chk("wrap_br_addr", instAddr, 32'hFFFF_FFFF);
        step();
        chk("wrap_addr", instAddr, 32'd0);
        chk("wrap_pp1", ifidPcPlus1, 32'd0);
        chk("wrap_inst", ifidInst, WRAP_WORD);
        chk("wrap_valid", {31'd0, ifidValid}, 32'd1);

        // Branch beats a jump word in fetch
        branchTaken = 1; branchTarget = 32'd5;
        step();
        chk("bj_at5", instAddr, 32'd5);
        branchTarget = 32'd20;
        step();
        branchTaken = 0;
        chk("bj_addr", instAddr, 32'd20);
        chk("bj_valid", {31'd0, ifidValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
